// File: rtl/wishbone_bus_if_pkg.sv
// wishbone_bus_if_pkg
//   Shared definitions for the CPU-side Wishbone initiator: bus widths, the
//   reset-active level, the initiator state encoding and a helper that sizes
//   the ack-timeout counter.
package wishbone_bus_if_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'd0,
    WB_BUSY           = 2'd1,
    WB_WAIT_FOR_STALL = 2'd2
  } wb_state_e;

  // Counter width for a given timeout; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/wishbone_bus_if_if.sv
// wishbone_bus_if_if
//   Classic Wishbone initiator/responder signal bundle.
//   master modport: drives addr, wdata, we, sel, stb, cyc; receives rdata, ack.
//   slave  modport: the mirror image, for responders and testbenches.
interface wishbone_bus_if_if;
  import wishbone_bus_if_pkg::*;

  logic [WB_DATA_W-1:0] addr;
  logic [WB_DATA_W-1:0] wdata;
  logic [WB_DATA_W-1:0] rdata;
  logic                 we;
  logic [WB_SEL_W-1:0]  sel;
  logic                 stb;
  logic                 cyc;
  logic                 ack;

  modport master (
    output addr, wdata, we, sel, stb, cyc,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, we, sel, stb, cyc,
    output rdata, ack
  );

endinterface

// File: rtl/wishbone_bus_if_wb_timeout_cnt.sv
// wb_timeout_cnt
//   Counts cycles spent waiting for an ack and flags the last permitted one.
//   clk/rst : clock and synchronous active-high reset
//   clr     : restart the count from zero (takes priority over en)
//   en      : advance the count by one
//   tc      : count has reached TIMEOUT_CYCLES-1
module wb_timeout_cnt
  import wishbone_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/wishbone_bus_if.sv
// wishbone_bus_if
//   Turns single-beat CPU memory requests into classic Wishbone cycles,
//   stalls the pipeline while a cycle is outstanding, holds read data while
//   the pipeline is stalled elsewhere, and aborts on flush or ack timeout.
//   clk, rst        : clock, synchronous active-high reset
//   cpu_*_i         : CPU request (ce, addr, data, we, sel) and pipeline stall
//   flush_i         : abandon any access in progress
//   cpu_data_o      : read data back to the CPU
//   stallreq_o      : stall request to the pipeline controller
//   bus_err_o       : one-cycle pulse when a cycle is aborted on timeout
//   wb              : Wishbone initiator port (all outputs registered)
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_ce_i,
  input  logic [WB_DATA_W-1:0] cpu_addr_i,
  input  logic [WB_DATA_W-1:0] cpu_data_i,
  input  logic                 cpu_we_i,
  input  logic [WB_SEL_W-1:0]  cpu_sel_i,
  input  logic                 cpu_stall_i,
  input  logic                 flush_i,
  output logic [WB_DATA_W-1:0] cpu_data_o,
  output logic                 stallreq_o,
  output logic                 bus_err_o,
  wishbone_bus_if_if.master    wb
);

  wb_state_e state, state_next;

  logic                 start;
  logic                 finish;
  logic                 capture;
  logic                 abort;
  logic                 cnt_en;
  logic                 timeout_hit;

  logic [WB_DATA_W-1:0] rd_buf;
  logic [WB_DATA_W-1:0] addr_q;
  logic [WB_DATA_W-1:0] wdata_q;
  logic                 we_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic                 active_q;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (cnt_en),
    .tc  (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= WB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ack is only honoured in BUSY, so a late ack after a flush or timeout
  // abort falls into IDLE/WAIT_FOR_STALL and is ignored.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    cnt_en     = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state)
      WB_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          start      = 1'b1;
          stallreq_o = 1'b1;
          state_next = WB_BUSY;
        end
      end
      WB_BUSY: begin
        if (flush_i) begin
          finish     = 1'b1;
          state_next = WB_IDLE;
        end else if (wb.ack) begin
          finish     = 1'b1;
          capture    = 1'b1;
          cpu_data_o = wb.rdata;
          state_next = cpu_stall_i ? WB_WAIT_FOR_STALL : WB_IDLE;
        end else if (timeout_hit) begin
          finish     = 1'b1;
          abort      = 1'b1;
          state_next = cpu_stall_i ? WB_WAIT_FOR_STALL : WB_IDLE;
        end else begin
          cnt_en     = 1'b1;
          stallreq_o = 1'b1;
        end
      end
      WB_WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
        if (!cpu_stall_i || flush_i) begin
          state_next = WB_IDLE;
        end
      end
      default: begin
        state_next = WB_IDLE;
      end
    endcase
  end

  // Bus fields load only from IDLE (stb low), so they never move while
  // stb is high; stb drops on every exit from BUSY, which guarantees the
  // one-cycle gap between transfers.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      active_q  <= 1'b0;
      rd_buf    <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= abort;
      if (start) begin
        addr_q   <= cpu_addr_i;
        wdata_q  <= cpu_data_i;
        we_q     <= cpu_we_i;
        sel_q    <= cpu_sel_i;
        active_q <= 1'b1;
      end else if (finish) begin
        active_q <= 1'b0;
      end
      if (capture) begin
        rd_buf <= wb.rdata;
      end else if (abort) begin
        rd_buf <= '0;
      end
    end
  end

  assign wb.addr  = addr_q;
  assign wb.wdata = wdata_q;
  assign wb.we    = we_q;
  assign wb.sel   = sel_q;
  assign wb.stb   = active_q;
  assign wb.cyc   = active_q;

endmodule
